// File: rtl/audio_i2s_tx_if.sv
// -----------------------------------------------------------------------------
// audio_i2s_tx_if
//
// Parallel stereo PCM handshake between a sample producer (for example the
// sound core's pcm_out) and the audio_i2s_tx serialiser.
//
// Signals:
//   SAMPLE_L      left PCM sample, two's complement
//   SAMPLE_R      right PCM sample, two's complement
//   SAMPLE_VALID  producer offers {SAMPLE_L, SAMPLE_R}
//   SAMPLE_READY  consumer holding buffer is empty; transfer on VALID && READY
//
// Modports:
//   master  producer side (drives samples and VALID)
//   slave   serialiser side (drives READY)
// -----------------------------------------------------------------------------
interface audio_i2s_tx_if #(
    parameter int DATA_W = 16
);
    logic signed [DATA_W-1:0] SAMPLE_L;
    logic signed [DATA_W-1:0] SAMPLE_R;
    logic                     SAMPLE_VALID;
    logic                     SAMPLE_READY;

    modport master (
        output SAMPLE_L,
        output SAMPLE_R,
        output SAMPLE_VALID,
        input  SAMPLE_READY
    );

    modport slave (
        input  SAMPLE_L,
        input  SAMPLE_R,
        input  SAMPLE_VALID,
        output SAMPLE_READY
    );
endinterface

// File: rtl/audio_i2s_tx.sv
// -----------------------------------------------------------------------------
// audio_i2s_tx
//
// I2S transmitter for 16-bit (DATA_W) stereo PCM. Samples arrive through a
// valid/ready handshake into a one-entry holding buffer and are serialised
// as SCLK/LRCK/SDATA. Everything runs on CLK_50M; SCLK is produced with a
// clock-enable style divider, so no derived clocks exist. When a frame load
// finds the buffer empty the previous frame is replayed and UNDERRUN pulses.
//
// Parameters:
//   DATA_W     bits per channel (slot width); a frame is 2*DATA_W SCLK periods
//   SCLK_HALF  CLK_50M cycles per SCLK half period (>= 2)
//
// Ports:
//   CLK_50M    system clock, rising edge
//   RESET_N    synchronous active-low reset
//   pcm        audio_i2s_tx_if.slave: SAMPLE_L/SAMPLE_R/SAMPLE_VALID in,
//              SAMPLE_READY out
//   I2S_SCLK   bit clock (registered)
//   I2S_LRCK   word select, 0 = left slot, 1 = right slot (registered)
//   I2S_SDATA  serial data, updated with the SCLK falling edge (registered)
//   UNDERRUN   one-cycle pulse when a frame load finds the buffer empty
//
// Build option:
//   AUDIO_TX_LJ_EN  when defined, left-justified format (no one-bit delay,
//                   frame load at the falling edge that begins slot 0, and
//                   the IDLE->RUN start cycle counts as that load). When
//                   undefined, standard I2S with the one-bit delay and the
//                   frame load at the falling edge that begins slot 1.
// -----------------------------------------------------------------------------
module audio_i2s_tx #(
    parameter int DATA_W    = 16,
    parameter int SCLK_HALF = 16
) (
    input  logic          CLK_50M,
    input  logic          RESET_N,
    audio_i2s_tx_if.slave pcm,
    output logic          I2S_SCLK,
    output logic          I2S_LRCK,
    output logic          I2S_SDATA,
    output logic          UNDERRUN
);

    localparam int FRAME_W = 2 * DATA_W;
    localparam int SLOT_W  = $clog2(FRAME_W);
    localparam int DIV_W   = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCLK_HALF - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(FRAME_W - 1);
    localparam logic [SLOT_W-1:0] SLOT_HALF = SLOT_W'(DATA_W);

    generate
        if (SCLK_HALF < 2) begin : g_bad_sclk_half
            $error("audio_i2s_tx: SCLK_HALF must be at least 2");
        end
    endgenerate

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Control state
    state_t              state_q,    state_d;
    logic [DIV_W-1:0]    div_q,      div_d;
    logic [SLOT_W-1:0]   slot_q,     slot_d;
    logic                sclk_q,     sclk_d;
    logic                lrck_q,     lrck_d;
    logic                sdata_q,    sdata_d;
    logic                underrun_q, underrun_d;
    logic                ready_q,    ready_d;
    logic                full_q,     full_d;
    // Frame currently being played; cleared by reset so the first I2S slot 0
    // after reset shifts out a defined zero.
    logic [FRAME_W-1:0]  frame_q,    frame_d;
    // Holding buffer contents; only meaningful while full_q is set.
    logic [FRAME_W-1:0]  hold_q,     hold_d;

    // Per-cycle events
    logic                accept;
    logic                start;
    logic                tick;
    logic                fall;
    logic                slot_edge;
    logic                load;
    logic [SLOT_W-1:0]   slot_next;
    logic [FRAME_W-1:0]  word_next;

`ifdef AUDIO_TX_LJ_EN
    // Left-justified: slot k carries bit (FRAME_W-1-k) of the frame word.
    function automatic logic slot_bit(input logic [FRAME_W-1:0] word,
                                      input logic [SLOT_W-1:0]  slot);
        logic [SLOT_W-1:0] idx;
        idx = SLOT_W'(FRAME_W - 1 - int'(slot));
        return word[idx];
    endfunction
`else
    // I2S: slot k>=1 carries bit (FRAME_W-k) of the new word; slot 0 carries
    // the LSB of the word that is finishing (the one-bit delay).
    function automatic logic slot_bit(input logic [FRAME_W-1:0] prev_word,
                                      input logic [FRAME_W-1:0] cur_word,
                                      input logic [SLOT_W-1:0]  slot);
        logic [SLOT_W-1:0] idx;
        idx = SLOT_W'(FRAME_W - int'(slot));
        if (slot == '0) begin
            return prev_word[0];
        end
        return cur_word[idx];
    endfunction
`endif

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        slot_d     = slot_q;
        sclk_d     = sclk_q;
        lrck_d     = lrck_q;
        sdata_d    = sdata_q;
        full_d     = full_q;
        hold_d     = hold_q;
        frame_d    = frame_q;
        underrun_d = 1'b0;
        ready_d    = ready_q;
        slot_next  = slot_q;
        word_next  = frame_q;
        load       = 1'b0;

        accept = pcm.SAMPLE_VALID & ready_q;
        // The first cycle with a full buffer in IDLE is div_cnt=0 of slot 0.
        start  = (state_q == IDLE) & full_q;
        tick   = (state_q == RUN) & (div_q == DIV_LAST);
        fall   = tick & sclk_q;

        case (state_q)
            IDLE: begin
                sclk_d  = 1'b0;
                lrck_d  = 1'b0;
                sdata_d = 1'b0;
                div_d   = '0;
                if (full_q) begin
                    state_d = RUN;
                    div_d   = DIV_W'(1);
                end
            end
            RUN: begin
                div_d = tick ? '0 : div_q + DIV_W'(1);
                if (tick) begin
                    sclk_d = ~sclk_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Slot that begins with this cycle's falling edge (or the start cycle).
        slot_edge = start | fall;
        if (start) begin
            slot_next = '0;
        end else if (fall) begin
            slot_next = (slot_q == SLOT_LAST) ? '0 : slot_q + SLOT_W'(1);
        end

`ifdef AUDIO_TX_LJ_EN
        load = slot_edge & (slot_next == '0);
`else
        load = fall & (slot_next == SLOT_W'(1));
`endif

        // On an empty-buffer load the previous frame is simply kept.
        if (load & full_q) begin
            word_next = hold_q;
        end
        frame_d    = word_next;
        underrun_d = load & ~full_q;

        if (load) begin
            full_d = 1'b0;
        end
        // READY is only high while the buffer is empty, so an accept can
        // never overwrite a held sample, even in a load cycle.
        if (accept) begin
            full_d = 1'b1;
            hold_d = {pcm.SAMPLE_L, pcm.SAMPLE_R};
        end
        ready_d = ~full_d;

        if (slot_edge) begin
            slot_d = slot_next;
            lrck_d = (slot_next >= SLOT_HALF);
`ifdef AUDIO_TX_LJ_EN
            sdata_d = slot_bit(word_next, slot_next);
`else
            sdata_d = slot_bit(frame_q, word_next, slot_next);
`endif
        end
    end

    // Control and frame registers
    always_ff @(posedge CLK_50M) begin
        if (!RESET_N) begin
            state_q    <= IDLE;
            div_q      <= '0;
            slot_q     <= '0;
            sclk_q     <= 1'b0;
            lrck_q     <= 1'b0;
            sdata_q    <= 1'b0;
            underrun_q <= 1'b0;
            ready_q    <= 1'b0;
            full_q     <= 1'b0;
            frame_q    <= '0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            slot_q     <= slot_d;
            sclk_q     <= sclk_d;
            lrck_q     <= lrck_d;
            sdata_q    <= sdata_d;
            underrun_q <= underrun_d;
            ready_q    <= ready_d;
            full_q     <= full_d;
            frame_q    <= frame_d;
        end
    end

    // Holding buffer data; emptiness is tracked by full_q alone.
    always_ff @(posedge CLK_50M) begin
        hold_q <= hold_d;
    end

    assign pcm.SAMPLE_READY = ready_q;
    assign I2S_SCLK         = sclk_q;
    assign I2S_LRCK         = lrck_q;
    assign I2S_SDATA        = sdata_q;
    assign UNDERRUN         = underrun_q;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// -----------------------------------------------------------------------------
// tb_audio_i2s_tx
//
// Scoreboard bench for audio_i2s_tx. The driver pushes every accepted sample
// (with the cycle index of its acceptance) into a queue; a monitor watches the
// serial outputs, decides at each frame load which word must play from the
// acceptance times alone, and reassembles the serial bits into frame words.
// -----------------------------------------------------------------------------
module tb_audio_i2s_tx;
    localparam int DATA_W    = 16;
    localparam int SCLK_HALF = 16;
    localparam int FW        = 2 * DATA_W;
    localparam int SCLK_P    = 2 * SCLK_HALF;
    localparam int FRAME_P   = FW * SCLK_P;
`ifdef AUDIO_TX_LJ_EN
    localparam int LOAD_AFTER_SLOT = FW - 1;
`else
    localparam int LOAD_AFTER_SLOT = 0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic sclk, lrck, sdata, underrun;

    audio_i2s_tx_if #(.DATA_W(DATA_W)) pcm ();

    audio_i2s_tx #(
        .DATA_W    (DATA_W),
        .SCLK_HALF (SCLK_HALF)
    ) dut (
        .CLK_50M   (clk),
        .RESET_N   (rst_n),
        .pcm       (pcm),
        .I2S_SCLK  (sclk),
        .I2S_LRCK  (lrck),
        .I2S_SDATA (sdata),
        .UNDERRUN  (underrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] w;
        int          idx;
    } ent_t;

    ent_t        sb[$];
    int          cnt         = 0;
    int          run_rises   = 0;
    int          last_rise_t = 0;
    int          last_lrck_t = -1;
    int          cur_slot    = 0;
    int          loads       = 0;
    int          last_acc    = 0;
    logic        psclk = 1'b0, plrck = 1'b0, psdata = 1'b0;
    logic [31:0] exp_word = '0;
    logic [31:0] got_word = '0;
    bit          have_exp = 0;
    bit          rise, fall, ldn;

    // Monitor: all decisions on the falling clk edge, driver acts 1ns later.
    always @(negedge clk) begin
        cnt++;
        ldn = 0;
        if (!rst_n) begin
            chk("reset_outputs", {27'd0, sclk, lrck, sdata, underrun, pcm.SAMPLE_READY}, 32'd0);
            sb.delete();
            run_rises   = 0;
            have_exp    = 0;
            last_lrck_t = -1;
            cur_slot    = 0;
            psclk       = 1'b0;
            plrck       = 1'b0;
            psdata      = 1'b0;
        end else begin
            rise = sclk && !psclk;
            fall = !sclk && psclk;
            if ((lrck !== plrck || sdata !== psdata) && run_rises > 0)
                chk("change_on_sclk_fall", fall, 1);
            if (rise) begin
                if (run_rises > 0) chk("sclk_period", cnt - last_rise_t, SCLK_P);
                cur_slot    = run_rises % FW;
                run_rises++;
                last_rise_t = cnt;
                chk("lrck_slot", lrck, (cur_slot >= DATA_W));
`ifdef AUDIO_TX_LJ_EN
                if (run_rises == 1) begin
                    chk("start_load_queue", sb.size(), 1);
                    if (sb.size() > 0) begin
                        exp_word = sb.pop_front().w;
                        have_exp = 1;
                    end
                end
                got_word[FW-1-cur_slot] = sdata;
                if (cur_slot == FW - 1 && have_exp) chk("frame_bits", got_word, exp_word);
`else
                if (run_rises == 1) begin
                    chk("first_slot0_bit", sdata, 0);
                end else begin
                    got_word[(FW - cur_slot) % FW] = sdata;
                    if (cur_slot == 0 && have_exp) chk("frame_bits", got_word, exp_word);
                end
`endif
            end
            if (fall && run_rises > 0 && cur_slot == LOAD_AFTER_SLOT) begin
                // The load happened at the posedge just before this negedge
                // (index cnt-1); a sample accepted at an earlier edge is used.
                ldn = 1;
                loads++;
                if (sb.size() > 0 && sb[0].idx <= cnt - 2) begin
                    exp_word = sb.pop_front().w;
                    chk("underrun_at_load", underrun, 0);
                    chk("ready_after_load", pcm.SAMPLE_READY, 1);
                end else begin
                    chk("underrun_at_load", underrun, 1);
                end
                have_exp = 1;
            end
            if (!ldn) chk("underrun_outside_load", underrun, 0);
            if (lrck && !plrck) begin
                if (last_lrck_t >= 0) chk("lrck_period", cnt - last_lrck_t, FRAME_P);
                last_lrck_t = cnt;
            end
            psclk  = sclk;
            plrck  = lrck;
            psdata = sdata;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Offer one sample; returns one cycle after the transfer. With hold=1
    // VALID stays high so the next call keeps the producer streaming.
    task automatic send(input logic [15:0] l, input logic [15:0] r, input bit hold);
        int waited;
        waited = 0;
        pcm.SAMPLE_L     = l;
        pcm.SAMPLE_R     = r;
        pcm.SAMPLE_VALID = 1'b1;
        while (pcm.SAMPLE_READY !== 1'b1 && waited < 3 * FRAME_P) begin
            step(1);
            waited++;
        end
        if (pcm.SAMPLE_READY !== 1'b1) begin
            chk("ready_timeout", pcm.SAMPLE_READY, 1);
            pcm.SAMPLE_VALID = 1'b0;
        end else begin
            sb.push_back('{w: {l, r}, idx: cnt});
            last_acc = cnt;
            step(1);
            chk("ready_after_accept", pcm.SAMPLE_READY, 0);
            if (!hold) pcm.SAMPLE_VALID = 1'b0;
        end
    endtask

    initial begin
        int prev_acc;
        int l0;
        int waited;

        // Reset held for 4 cycles with VALID asserted.
        pcm.SAMPLE_L     = 16'($urandom);
        pcm.SAMPLE_R     = 16'($urandom);
        pcm.SAMPLE_VALID = 1'b1;
        rst_n            = 1'b0;
        step(4);
        rst_n            = 1'b1;
        pcm.SAMPLE_VALID = 1'b0;
        step(1);
        chk("ready_after_release", pcm.SAMPLE_READY, 1);

        // Single frame, then starve it: frame 2 repeats with an underrun.
        send(16'hA5F0, 16'h0F0F, 0);
        step(3 * FRAME_P);

        // Pattern exercising MSB/LSB slot placement.
        send(16'h8001, 16'h0001, 0);
        step(2 * FRAME_P);

        // Random samples with random gaps (some gaps cause underruns).
        for (int i = 0; i < 6; i++) begin
            send(16'($urandom), 16'($urandom), 0);
            step($urandom_range(0, 2 * FRAME_P));
        end

        // Back-pressure: VALID held, incrementing data, one accept per frame.
        prev_acc = 0;
        for (int i = 0; i < 6; i++) begin
            send(16'(16'h1000 + i), 16'(16'h2000 + i), (i < 5));
            if (i >= 2) chk("accept_interval", last_acc - prev_acc, FRAME_P);
            prev_acc = last_acc;
        end
        step(2 * FRAME_P);

        // Mid-frame reset in slot 20 with a sample held in the buffer.
        l0     = loads;
        waited = 0;
        while (loads == l0 && waited < 2 * FRAME_P) begin
            step(1);
            waited++;
        end
        send(16'hDEAD, 16'hBEEF, 0);
        waited = 0;
        while (cur_slot != 20 && waited < 2 * FRAME_P) begin
            step(1);
            waited++;
        end
        chk("reach_slot20", cur_slot, 20);
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
        chk("ready_after_mid_reset", pcm.SAMPLE_READY, 1);
        send(16'h1234, 16'h5678, 0);
        step(3 * FRAME_P);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
